octave_ctrl: RTL and testbench

OCTAVE_CTRL -- requirements
Module: octave_ctrl

---
 rtl/octave_pkg.sv | 21 ++
 rtl/key_repeat.sv | 95 +++++++++
 rtl/octave_ctrl.sv | 89 ++++++++
 tb/tb_octave_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/octave_pkg.sv
// Shared definitions for the octave controller: per-key FSM state encoding
// and the default parameter values used by octave_ctrl and key_repeat.
package octave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_DELAY,
    ST_REPEAT,
    ST_LOCK
  } key_state_t;

  localparam int DEF_OCT_W     = 3;
  localparam int DEF_OCT_MIN   = 1;
  localparam int DEF_OCT_MAX   = 7;
  localparam int DEF_OCT_INIT  = 4;
  localparam int DEF_WRAP      = 0;
  localparam int DEF_RPT_DELAY = 25000000;
  localparam int DEF_RPT_RATE  = 12500000;

endpackage

// File: rtl/key_repeat.sv
// One button: 2-flop synchroniser, press/auto-repeat FSM and hold counter.
// step is a one-cycle request; lock parks the FSM until its key is released.
module key_repeat
  import octave_pkg::*;
#(
  parameter int RPT_DELAY = DEF_RPT_DELAY,
  parameter int RPT_RATE  = DEF_RPT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  input  logic lock,
  output logic key_s,
  output logic step
);

  localparam int CNT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_END  = CNT_W'(RPT_RATE - 1);

  logic             key_p0;
  logic             key_p1;
  key_state_t       state;
  key_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign key_s = key_p1;

  // stage p0/p1: metastability filter on the raw button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= 1'b0;
      key_p1 <= 1'b0;
    end else begin
      key_p0 <= key;
      key_p1 <= key_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step      = 1'b0;
    if (lock) begin
      state_nxt = ST_LOCK;
      cnt_nxt   = '0;
    end else if (!key_p1) begin
      // a single-cycle press has already dropped by the time FIRE is reached
      step      = (state == ST_FIRE);
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_IDLE:   state_nxt = ST_FIRE;
        ST_FIRE: begin
          step      = 1'b1;
          state_nxt = ST_DELAY;
          cnt_nxt   = '0;
        end
        ST_DELAY: begin
          if (cnt == DELAY_END) begin
            step      = 1'b1;
            state_nxt = ST_REPEAT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (cnt == RATE_END) begin
            step    = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_LOCK:   state_nxt = ST_LOCK;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/octave_ctrl.sv
// Octave selector driven by up/down buttons with auto-repeat, limit
// saturation or wrap, and a both-buttons preset back to OCT_INIT.
module octave_ctrl
  import octave_pkg::*;
#(
  parameter int OCT_W     = DEF_OCT_W,
  parameter int OCT_MIN   = DEF_OCT_MIN,
  parameter int OCT_MAX   = DEF_OCT_MAX,
  parameter int OCT_INIT  = DEF_OCT_INIT,
  parameter int WRAP      = DEF_WRAP,
  parameter int RPT_DELAY = DEF_RPT_DELAY,
  parameter int RPT_RATE  = DEF_RPT_RATE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             down,
  output logic [OCT_W-1:0] octave,
  output logic             changed,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [OCT_W-1:0] MIN_V  = OCT_W'(OCT_MIN);
  localparam logic [OCT_W-1:0] MAX_V  = OCT_W'(OCT_MAX);
  localparam logic [OCT_W-1:0] INIT_V = OCT_W'(OCT_INIT);

  logic             up_s;
  logic             down_s;
  logic             up_req;
  logic             down_req;
  logic             preset;
  logic [OCT_W-1:0] oct_nxt;

  function automatic logic [OCT_W-1:0] step_up(input logic [OCT_W-1:0] o);
    if (o < MAX_V)  return o + 1'b1;
    if (WRAP != 0)  return MIN_V;
    return o;
  endfunction

  function automatic logic [OCT_W-1:0] step_down(input logic [OCT_W-1:0] o);
    if (o > MIN_V)  return o - 1'b1;
    if (WRAP != 0)  return MAX_V;
    return o;
  endfunction

  assign preset = up_s & down_s;

  key_repeat #(.RPT_DELAY(RPT_DELAY), .RPT_RATE(RPT_RATE)) u_up (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (up),
    .lock  (preset),
    .key_s (up_s),
    .step  (up_req)
  );

  key_repeat #(.RPT_DELAY(RPT_DELAY), .RPT_RATE(RPT_RATE)) u_down (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (down),
    .lock  (preset),
    .key_s (down_s),
    .step  (down_req)
  );

  // simultaneous opposing requests cancel; preset outranks both
  always_comb begin
    oct_nxt = octave;
    if (preset)                   oct_nxt = INIT_V;
    else if (up_req && !down_req) oct_nxt = step_up(octave);
    else if (down_req && !up_req) oct_nxt = step_down(octave);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      octave  <= INIT_V;
      changed <= 1'b0;
      at_min  <= (INIT_V == MIN_V);
      at_max  <= (INIT_V == MAX_V);
    end else begin
      octave  <= oct_nxt;
      changed <= (oct_nxt != octave);
      at_min  <= (oct_nxt == MIN_V);
      at_max  <= (oct_nxt == MAX_V);
    end
  end

endmodule

// File: tb/tb_octave_ctrl.sv
// Scoreboard bench: a saturating and a wrapping octave_ctrl share stimulus;
// expected octave changes (value and landing cycle) are queued per instance.
module tb_octave_ctrl;

  localparam int OCT_W  = 3;
  localparam int O_MIN  = 1;
  localparam int O_MAX  = 7;
  localparam int O_INIT = 4;
  localparam int DLY    = 8;
  localparam int RATE   = 4;

  typedef struct {
    int oct;
    int cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             up = 1'b0;
  logic             down = 1'b0;
  logic [OCT_W-1:0] oct0, oct1;
  logic             chg0, chg1, min0, min1, max0, max1;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   m0, m1;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  octave_ctrl #(.OCT_W(OCT_W), .OCT_MIN(O_MIN), .OCT_MAX(O_MAX), .OCT_INIT(O_INIT),
                .WRAP(0), .RPT_DELAY(DLY), .RPT_RATE(RATE)) dut_sat (
    .clk(clk), .rst_n(rst_n), .up(up), .down(down),
    .octave(oct0), .changed(chg0), .at_min(min0), .at_max(max0));

  octave_ctrl #(.OCT_W(OCT_W), .OCT_MIN(O_MIN), .OCT_MAX(O_MAX), .OCT_INIT(O_INIT),
                .WRAP(1), .RPT_DELAY(DLY), .RPT_RATE(RATE)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .up(up), .down(down),
    .octave(oct1), .changed(chg1), .at_min(min1), .at_max(max1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  function automatic int model_up(input int o, input bit wrap);
    if (o == O_MAX) return wrap ? O_MIN : o;
    return o + 1;
  endfunction

  function automatic int model_down(input int o, input bit wrap);
    if (o == O_MIN) return wrap ? O_MAX : o;
    return o - 1;
  endfunction

  task automatic push_new(input int n0, input int n1, input int at);
    if (n0 != m0) q0.push_back('{oct: n0, cyc: at});
    if (n1 != m1) q1.push_back('{oct: n1, cyc: at});
    m0 = n0;
    m1 = n1;
  endtask

  task automatic push_step(input bit dn, input int at);
    if (dn) push_new(model_down(m0, 1'b0), model_down(m1, 1'b1), at);
    else    push_new(model_up(m0, 1'b0),   model_up(m1, 1'b1),   at);
  endtask

  // every queued change must have appeared and both octaves must match the model
  task automatic expect_idle(input string tag);
    chk({tag, "_pend_sat"},  q0.size(), 0);
    chk({tag, "_pend_wrap"}, q1.size(), 0);
    chk({tag, "_oct_sat"},   int'(oct0), m0);
    chk({tag, "_oct_wrap"},  int'(oct1), m1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_oct"},    int'(oct0), O_INIT);
    chk({tag, "_chg"},    int'(chg0), 0);
    chk({tag, "_min"},    int'(min0), 0);
    chk({tag, "_max"},    int'(max0), 0);
    chk({tag, "_oct_w"},  int'(oct1), O_INIT);
    chk({tag, "_chg_w"},  int'(chg1), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    up    = 1'b0;
    down  = 1'b0;
    m0 = O_INIT;
    m1 = O_INIT;
    q0.delete();
    q1.delete();
    #1 check_reset_state(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one-cycle-wide press: first step lands four rising edges later
  task automatic pulse(input bit dn);
    int c;
    @(negedge clk);
    c = cyc;
    if (dn) down = 1'b1; else up = 1'b1;
    push_step(dn, c + 4);
    @(negedge clk);
    up   = 1'b0;
    down = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && chg0) begin
      if (q0.size() == 0) chk("unexpected_change_sat", int'(oct0), m0);
      else begin
        e0 = q0.pop_front();
        chk("oct_sat", int'(oct0), e0.oct);
        chk("when_sat", cyc, e0.cyc);
        chk("at_min_sat", int'(min0), int'(e0.oct == O_MIN));
        chk("at_max_sat", int'(max0), int'(e0.oct == O_MAX));
      end
    end
    if (rst_n && chg1) begin
      if (q1.size() == 0) chk("unexpected_change_wrap", int'(oct1), m1);
      else begin
        e1 = q1.pop_front();
        chk("oct_wrap", int'(oct1), e1.oct);
        chk("when_wrap", cyc, e1.cyc);
        chk("at_min_wrap", int'(min1), int'(e1.oct == O_MIN));
        chk("at_max_wrap", int'(max1), int'(e1.oct == O_MAX));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int r;
    m0 = O_INIT;
    m1 = O_INIT;
    repeat (2) @(negedge clk);
    #1 check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // three single presses climb 4 -> 7
    for (int i = 0; i < 3; i++) pulse(1'b0);
    expect_idle("climb");
    chk("climb_at_max", int'(max0), 1);

    // at the top: saturating instance holds, wrapping instance rolls to OCT_MIN
    pulse(1'b0);
    expect_idle("limit");
    chk("limit_at_max_sat", int'(max0), 1);
    chk("limit_at_min_wrap", int'(min1), 1);

    // held down from 7: FIRE, +8, then every 4 cycles
    do_reset("reset2");
    pulse(1'b0);
    pulse(1'b0);
    pulse(1'b0);
    @(negedge clk);
    c = cyc;
    down = 1'b1;
    push_step(1'b1, c + 4);
    for (int k = 12; k <= 32; k += 4) push_step(1'b1, c + k);
    repeat (30) @(negedge clk);
    down = 1'b0;
    repeat (10) @(negedge clk);
    expect_idle("hold_down");
    chk("hold_down_at_min", int'(min0), 1);

    // preset: up then down one cycle later jumps 6 -> 4, then both lock
    do_reset("reset3");
    pulse(1'b0);
    pulse(1'b0);
    @(negedge clk);
    c = cyc;
    up = 1'b1;
    @(negedge clk);
    down = 1'b1;
    push_new(O_INIT, O_INIT, c + 4);
    repeat (20) @(negedge clk);
    up = 1'b0;
    repeat (20) @(negedge clk);
    down = 1'b0;
    repeat (6) @(negedge clk);
    expect_idle("preset");
    pulse(1'b1);
    expect_idle("after_preset");

    // reset while repeating at octave 2, with up held through release
    do_reset("reset4");
    @(negedge clk);
    c = cyc;
    down = 1'b1;
    push_step(1'b1, c + 4);
    push_step(1'b1, c + 12);
    repeat (14) @(negedge clk);
    expect_idle("pre_reset");
    rst_n = 1'b0;
    down  = 1'b0;
    up    = 1'b1;
    m0 = O_INIT;
    m1 = O_INIT;
    q0.delete();
    q1.delete();
    #1 check_reset_state("mid_repeat_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    push_step(1'b0, r + 4);
    repeat (6) @(negedge clk);
    up = 1'b0;
    repeat (10) @(negedge clk);
    expect_idle("held_through_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
